// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant between the ALU and load unit,
// registered register-file write stage, forwarding compare and a saturating
// conflict counter. rst_n is active-high and asynchronous.
module wb_arbiter #(
  parameter int DATAW = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [DATAW-1:0] alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [DATAW-1:0] mem_data,
  output logic             mem_ready,
  input  logic             wb_hold,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [DATAW-1:0] rf_wdata,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_fwd_hit,
  output logic             rs2_fwd_hit,
  output logic [DATAW-1:0] rs1_fwd_data,
  output logic [DATAW-1:0] rs2_fwd_data,
  output logic [CNTW-1:0]  conflict_cnt
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e last_grant;
  grant_e last_grant_nxt;
  logic   alu_xfer;
  logic   mem_xfer;

  assign alu_xfer = alu_valid & alu_ready;
  assign mem_xfer = mem_valid & mem_ready;

  // Last-grant register; reset to MEM so the ALU wins the first tie
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      last_grant <= GRANT_MEM;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // Next grant owner: follows whichever requester actually transferred
  always_comb begin
    last_grant_nxt = last_grant;
    if (alu_xfer) begin
      last_grant_nxt = GRANT_ALU;
    end else if (mem_xfer) begin
      last_grant_nxt = GRANT_MEM;
    end
  end

  // Ready generation: blocked by hold/reset, ties go to the loser of the last grant
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst_n && !wb_hold) begin
      if (alu_valid && (!mem_valid || last_grant == GRANT_MEM)) begin
        alu_ready = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end
    end
  end

  // Registered write stage: pulse rf_we per accepted request, never for x0
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (alu_xfer) begin
      rf_we    <= (alu_rd != 5'd0);
      rf_rd    <= alu_rd;
      rf_wdata <= alu_data;
    end else if (mem_xfer) begin
      rf_we    <= (mem_rd != 5'd0);
      rf_rd    <= mem_rd;
      rf_wdata <= mem_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Saturating count of cycles where both requesters are valid
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      conflict_cnt <= '0;
    end else if (alu_valid && mem_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Bypass compare against the registered write stage
  always_comb begin
    rs1_fwd_hit  = rf_we && (rf_rd == rs1_addr) && (rs1_addr != 5'd0);
    rs2_fwd_hit  = rf_we && (rf_rd == rs2_addr) && (rs2_addr != 5'd0);
    rs1_fwd_data = rf_wdata;
    rs2_fwd_data = rf_wdata;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DATAW, default 32, width of write-back data.
REQ-002 Parameter: CNTW, default 16, width of the conflict counter.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous reset, active-high despite the suffix; asserting it clears state immediately, independent of clk.
REQ-005 Port: alu_valid  in  1  ALU write-back request.
REQ-006 Port: alu_rd  in  5  ALU destination register.
REQ-007 Port: alu_data  in  DATAW  ALU result.
REQ-008 Port: alu_ready  out  1  ALU request accepted this cycle.
REQ-009 Port: mem_valid  in  1  load-unit write-back request.
REQ-010 Port: mem_rd  in  5  load destination register.
REQ-011 Port: mem_data  in  DATAW  load data.
REQ-012 Port: mem_ready  out  1  load request accepted this cycle.
REQ-013 Port: wb_hold  in  1  blocks new grants while high.
REQ-014 Port: rf_we / rf_rd / rf_wdata  out  1 / 5 / DATAW  register-file write port (drives W_en, Rd, Wr_data).
REQ-015 Port: rs1_addr, rs2_addr  in  5 each  decode-stage source addresses.
REQ-016 Port: rs1_fwd_hit, rs2_fwd_hit  out  1 each  bypass match.
REQ-017 Port: rs1_fwd_data, rs2_fwd_data  out  DATAW each  bypass data.
REQ-018 Port: conflict_cnt  out  CNTW  cycles with both requesters valid.

Function
REQ-019 Handshake: a request transfers in a cycle when valid and ready are both high; ready is combinational from valids, wb_hold and last_grant.
REQ-020 wb_hold=1: alu_ready=mem_ready=0, no transfer; requesters keep valid and payload stable.
REQ-021 Exactly one valid and wb_hold=0: that requester gets ready=1.
REQ-022 Both valid and wb_hold=0: grant the requester not granted last (round-robin); the other sees ready=0.
REQ-023 last_grant register: 1 bit, 0=ALU, 1=MEM; updated only on a transfer to the granted requester.
REQ-024 Never both readies high in one cycle.
REQ-025 Output stage registered, latency 1: on transfer, next cycle rf_rd/rf_wdata = granted rd/data, rf_we = (rd != 0).
REQ-026 Transfer with rd=0 completes the handshake but produces rf_we=0 (x0 never written).
REQ-027 No transfer: next cycle rf_we=0; rf_rd/rf_wdata hold their previous values.
REQ-028 rf_we is a one-cycle pulse per accepted request; back-to-back transfers give consecutive pulses.
REQ-029 Forwarding: rsN_fwd_hit = rf_we AND rf_rd==rsN_addr AND rsN_addr!=0; rsN_fwd_data = rf_wdata always. Combinational from registered stage.
REQ-030 conflict_cnt increments by 1 each cycle with alu_valid AND mem_valid (regardless of wb_hold), saturating at all-ones, no wrap.

Reset
REQ-031 While rst_n=1: rf_we=0, rf_rd=0, rf_wdata=0, last_grant=1 (ALU wins first tie), conflict_cnt=0, alu_ready=mem_ready=0.
REQ-032 Reset mid-transfer discards the in-flight output-stage write; no rf_we pulse after release until a new transfer.
REQ-033 First transfer possible in the first rising edge after rst_n deasserts.

Verification
REQ-034 Only alu_valid, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF.
REQ-035 Both valid 4 cycles after reset, valids held -> grants ALU, MEM, ALU, MEM; rf_we pulses 4 consecutive cycles; conflict_cnt=4.
REQ-036 mem_valid, rd=0, data=0x1234 -> mem_ready=1; next cycle rf_we=0, rsN_fwd_hit=0 with rsN_addr=0.
REQ-037 wb_hold=1 for 3 cycles with both valid -> both readies 0, rf_we=0 those cycles; hold release -> grant per last_grant.
REQ-038 rf_we=1, rf_rd=7, rf_wdata=0x55; rs1_addr=7, rs2_addr=8 -> rs1_fwd_hit=1, rs1_fwd_data=0x55, rs2_fwd_hit=0.
REQ-039 CNTW=2, both valid 6 cycles -> conflict_cnt 1,2,3,3,3,3; assert rst_n async mid-cycle -> all outputs 0 before next edge.
